rvv_strip_sequencer: RTL and testbench

- Sequential successor to the combinational vl-setup logic. Accepts one vector configuration (vsew, vlmul, AVL) per handshake.
- Computes VLMAX and validity once per configuration, then strip-mines the AVL, issuing one vl per strip over a valid/ready handshake until the AVL is exhausted.
- Sits between the vector decode/issue stage and the vector lane controller.
- Generalised in VLEN, ELEN and AVL width. Supports fractional LMUL and abort.

---
 rtl/rvv_pkg.sv | 55 +++++
 rtl/rvv_vlmax_calc.sv | 39 +++
 rtl/rvv_strip_sequencer.sv | 175 +++++++++++++++++
 tb/tb_rvv_strip_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_pkg.sv
// Shared RVV definitions: vtype field encodings, sequencer states, SEW helper.
package rvv_pkg;

    localparam logic [2:0] VSEW_8   = 3'b000;
    localparam logic [2:0] VSEW_16  = 3'b001;
    localparam logic [2:0] VSEW_32  = 3'b010;
    localparam logic [2:0] VSEW_64  = 3'b011;
    localparam logic [2:0] VSEW_128 = 3'b100;

    localparam logic [2:0] VLMUL_1    = 3'b000;
    localparam logic [2:0] VLMUL_2    = 3'b001;
    localparam logic [2:0] VLMUL_4    = 3'b010;
    localparam logic [2:0] VLMUL_8    = 3'b011;
    localparam logic [2:0] VLMUL_RSVD = 3'b100;
    localparam logic [2:0] VLMUL_F8   = 3'b101;
    localparam logic [2:0] VLMUL_F4   = 3'b110;
    localparam logic [2:0] VLMUL_F2   = 3'b111;

    typedef enum logic [2:0] {
        SEW8   = 3'b000,
        SEW16  = 3'b001,
        SEW32  = 3'b010,
        SEW64  = 3'b011,
        SEW128 = 3'b100
    } vsew_e;

    typedef enum logic [2:0] {
        LMUL1  = 3'b000,
        LMUL2  = 3'b001,
        LMUL4  = 3'b010,
        LMUL8  = 3'b011,
        LMULF8 = 3'b101,
        LMULF4 = 3'b110,
        LMULF2 = 3'b111
    } vlmul_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2
    } seq_state_e;

    // Element width in bits for a vsew encoding; reserved encodings map to 0.
    function automatic int unsigned sew_bits(input logic [2:0] vsew);
        case (vsew)
            VSEW_8:   return 8;
            VSEW_16:  return 16;
            VSEW_32:  return 32;
            VSEW_64:  return 64;
            VSEW_128: return 128;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/rvv_vlmax_calc.sv
// Combinational VLMAX and legality from vsew/vlmul; shared with vsetvl decode.
module rvv_vlmax_calc
    import rvv_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int ELEN = 64,
    parameter int VL_W = $clog2(VLEN + 1)
) (
    input  logic [2:0]      vsew_i,
    input  logic [2:0]      vlmul_i,
    output logic [VL_W-1:0] vlmax_o,
    output logic            vill_o
);

    logic        sew_ok;
    logic        lmul_ok;
    int unsigned base;
    int unsigned shifted;

    // Elements per register at this SEW, scaled up or down by LMUL; zero result means unusable.
    always_comb begin
        sew_ok  = (vsew_i <= VSEW_128) && (sew_bits(vsew_i) <= 32'(ELEN));
        lmul_ok = (vlmul_i != VLMUL_RSVD);
        base    = 32'(VLEN) >> (32'd3 + 32'(vsew_i));
        if (vlmul_i[2]) begin
            shifted = base >> (4'd8 - {1'b0, vlmul_i});
        end else begin
            shifted = base << vlmul_i[1:0];
        end
        if (!sew_ok || !lmul_ok || (shifted == 32'd0)) begin
            vill_o  = 1'b1;
            vlmax_o = '0;
        end else begin
            vill_o  = 1'b0;
            vlmax_o = VL_W'(shifted);
        end
    end

endmodule

// File: rtl/rvv_strip_sequencer.sv
// Strip-mining sequencer: takes one vector configuration, then issues vl strips until AVL is used up.
module rvv_strip_sequencer
    import rvv_pkg::*;
#(
    parameter  int VLEN  = 128,
    parameter  int ELEN  = 64,
    parameter  int AVL_W = 16,
    localparam int VL_W  = $clog2(VLEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_vsew,
    input  logic [2:0]        cfg_vlmul,
    input  logic [AVL_W-1:0]  cfg_avl,
    output logic              strip_valid,
    input  logic              strip_ready,
    output logic [VL_W-1:0]   strip_vl,
    output logic              strip_last,
    output logic [AVL_W-1:0]  avl_remaining,
    output logic [VL_W-1:0]   vlmax,
    output logic              vill,
    input  logic              abort,
    output logic              done
);

    localparam int CW = (AVL_W > VL_W) ? AVL_W : VL_W;

    seq_state_e        state_q, state_d;
    logic [2:0]        vsew_q, vsew_d;
    logic [2:0]        vlmul_q, vlmul_d;
    logic [AVL_W-1:0]  avl_q, avl_d;
    logic [VL_W-1:0]   strip_vl_q, strip_vl_d;
    logic              strip_last_q, strip_last_d;
    logic [AVL_W-1:0]  avl_rem_q, avl_rem_d;
    logic [VL_W-1:0]   vlmax_q, vlmax_d;
    logic              vill_q, vill_d;
    logic              done_q, done_d;

    logic [VL_W-1:0]   calc_vlmax;
    logic              calc_vill;
    logic [CW-1:0]     src_ext;
    logic [CW-1:0]     lim_ext;
    logic [CW-1:0]     take_ext;
    logic [CW-1:0]     left_ext;

    rvv_vlmax_calc #(
        .VLEN (VLEN),
        .ELEN (ELEN),
        .VL_W (VL_W)
    ) u_vlmax_calc (
        .vsew_i  (vsew_q),
        .vlmul_i (vlmul_q),
        .vlmax_o (calc_vlmax),
        .vill_o  (calc_vill)
    );

    // Size of the next strip: the first strip draws from the full AVL, later ones from what is left.
    always_comb begin
        if (state_q == S_CALC) begin
            src_ext = CW'(avl_q);
            lim_ext = CW'(calc_vlmax);
        end else begin
            src_ext = CW'(avl_rem_q);
            lim_ext = CW'(vlmax_q);
        end
        take_ext = (src_ext < lim_ext) ? src_ext : lim_ext;
        left_ext = src_ext - take_ext;
    end

    // Next-state logic; abort wins over a simultaneous strip_ready so that strip is not consumed.
    always_comb begin
        state_d      = state_q;
        vsew_d       = vsew_q;
        vlmul_d      = vlmul_q;
        avl_d        = avl_q;
        strip_vl_d   = strip_vl_q;
        strip_last_d = strip_last_q;
        avl_rem_d    = avl_rem_q;
        vlmax_d      = vlmax_q;
        vill_d       = vill_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    vsew_d  = cfg_vsew;
                    vlmul_d = cfg_vlmul;
                    avl_d   = cfg_avl;
                    vill_d  = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (abort) begin
                    avl_rem_d = '0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    vlmax_d = calc_vlmax;
                    vill_d  = calc_vill;
                    if (calc_vill || (avl_q == '0)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        strip_vl_d   = VL_W'(take_ext);
                        avl_rem_d    = AVL_W'(left_ext);
                        strip_last_d = (left_ext == '0);
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    strip_vl_d   = '0;
                    strip_last_d = 1'b0;
                    avl_rem_d    = '0;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else if (strip_ready) begin
                    if (strip_last_q) begin
                        strip_vl_d   = '0;
                        strip_last_d = 1'b0;
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        strip_vl_d   = VL_W'(take_ext);
                        avl_rem_d    = AVL_W'(left_ext);
                        strip_last_d = (left_ext == '0);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vsew_q       <= '0;
            vlmul_q      <= '0;
            avl_q        <= '0;
            strip_vl_q   <= '0;
            strip_last_q <= 1'b0;
            avl_rem_q    <= '0;
            vlmax_q      <= '0;
            vill_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsew_q       <= vsew_d;
            vlmul_q      <= vlmul_d;
            avl_q        <= avl_d;
            strip_vl_q   <= strip_vl_d;
            strip_last_q <= strip_last_d;
            avl_rem_q    <= avl_rem_d;
            vlmax_q      <= vlmax_d;
            vill_q       <= vill_d;
            done_q       <= done_d;
        end
    end

    assign cfg_ready     = (state_q == S_IDLE);
    assign strip_valid   = (state_q == S_ISSUE);
    assign strip_vl      = strip_vl_q;
    assign strip_last    = strip_last_q;
    assign avl_remaining = avl_rem_q;
    assign vlmax         = vlmax_q;
    assign vill          = vill_q;
    assign done          = done_q;

endmodule

// File: tb/tb_rvv_strip_sequencer.sv
// Directed testbench for rvv_strip_sequencer at VLEN=128, ELEN=64, AVL_W=16.
module tb_rvv_strip_sequencer;

    localparam int VLEN  = 128;
    localparam int ELEN  = 64;
    localparam int AVL_W = 16;
    localparam int VL_W  = $clog2(VLEN + 1);

    logic              clk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_vsew;
    logic [2:0]        cfg_vlmul;
    logic [AVL_W-1:0]  cfg_avl;
    logic              strip_valid;
    logic              strip_ready;
    logic [VL_W-1:0]   strip_vl;
    logic              strip_last;
    logic [AVL_W-1:0]  avl_remaining;
    logic [VL_W-1:0]   vlmax;
    logic              vill;
    logic              abort;
    logic              done;

    int checks = 0;
    int errors = 0;

    rvv_strip_sequencer #(
        .VLEN  (VLEN),
        .ELEN  (ELEN),
        .AVL_W (AVL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_vsew      (cfg_vsew),
        .cfg_vlmul     (cfg_vlmul),
        .cfg_avl       (cfg_avl),
        .strip_valid   (strip_valid),
        .strip_ready   (strip_ready),
        .strip_vl      (strip_vl),
        .strip_last    (strip_last),
        .avl_remaining (avl_remaining),
        .vlmax         (vlmax),
        .vill          (vill),
        .abort         (abort),
        .done          (done)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One comparison of an observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one configuration, confirm it is accepted on this edge, then drop cfg_valid.
    task automatic applyStimulus(input logic [2:0] sew, input logic [2:0] lmul, input logic [AVL_W-1:0] avl);
        cfg_vsew  = sew;
        cfg_vlmul = lmul;
        cfg_avl   = avl;
        cfg_valid = 1'b1;
        checkOutput("cfg_ready_before_accept", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        checkOutput("cfg_ready_in_calc", 32'(cfg_ready), 32'd0);
        checkOutput("strip_valid_in_calc", 32'(strip_valid), 32'd0);
    endtask

    // Check the presented strip descriptor.
    task automatic checkStrip(input string tag, input int vl, input int rem, input logic last);
        checkOutput({tag, "_valid"}, 32'(strip_valid), 32'd1);
        checkOutput({tag, "_vl"}, 32'(strip_vl), 32'(vl));
        checkOutput({tag, "_rem"}, 32'(avl_remaining), 32'(rem));
        checkOutput({tag, "_last"}, 32'(strip_last), 32'(last));
    endtask

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_vsew    = '0;
        cfg_vlmul   = '0;
        cfg_avl     = '0;
        strip_ready = 1'b0;
        abort       = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_strip_valid", 32'(strip_valid), 32'd0);
        checkOutput("rst_strip_vl", 32'(strip_vl), 32'd0);
        checkOutput("rst_strip_last", 32'(strip_last), 32'd0);
        checkOutput("rst_avl_rem", 32'(avl_remaining), 32'd0);
        checkOutput("rst_vlmax", 32'(vlmax), 32'd0);
        checkOutput("rst_vill", 32'(vill), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // SEW8 LMUL1 avl=40: strips 16,16,8 back to back
        applyStimulus(3'b000, 3'b000, 16'd40);
        tick();
        checkOutput("t1_vlmax", 32'(vlmax), 32'd16);
        checkOutput("t1_vill", 32'(vill), 32'd0);
        checkStrip("t1_s0", 16, 24, 1'b0);
        strip_ready = 1'b1;
        tick();
        checkStrip("t1_s1", 16, 8, 1'b0);
        tick();
        checkStrip("t1_s2", 8, 0, 1'b1);
        tick();
        strip_ready = 1'b0;
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_valid_off", 32'(strip_valid), 32'd0);
        checkOutput("t1_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        checkOutput("t1_done_pulse_end", 32'(done), 32'd0);
        checkOutput("t1_vlmax_hold", 32'(vlmax), 32'd16);

        // SEW32 LMUL1/2 avl=3 with a 5-cycle stall
        applyStimulus(3'b010, 3'b111, 16'd3);
        tick();
        checkOutput("t2_vlmax", 32'(vlmax), 32'd2);
        checkStrip("t2_s0", 2, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkStrip("t2_stall", 2, 1, 1'b0);
        end
        strip_ready = 1'b1;
        tick();
        checkStrip("t2_s1", 1, 0, 1'b1);
        tick();
        strip_ready = 1'b0;
        checkOutput("t2_done", 32'(done), 32'd1);
        checkOutput("t2_valid_off", 32'(strip_valid), 32'd0);
        tick();

        // SEW64 LMUL1/8 -> vlmax 0, illegal
        applyStimulus(3'b011, 3'b101, 16'd10);
        tick();
        checkOutput("t3_vill", 32'(vill), 32'd1);
        checkOutput("t3_vlmax", 32'(vlmax), 32'd0);
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_no_strip", 32'(strip_valid), 32'd0);
        checkOutput("t3_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        checkOutput("t3_done_end", 32'(done), 32'd0);
        checkOutput("t3_vill_sticky", 32'(vill), 32'd1);
        checkOutput("t3_no_strip_later", 32'(strip_valid), 32'd0);

        // Reserved vsew=101 is also illegal; vill clears on accept then re-asserts
        applyStimulus(3'b101, 3'b000, 16'd10);
        checkOutput("t3b_vill_cleared", 32'(vill), 32'd0);
        tick();
        checkOutput("t3b_vill", 32'(vill), 32'd1);
        checkOutput("t3b_done", 32'(done), 32'd1);
        checkOutput("t3b_no_strip", 32'(strip_valid), 32'd0);
        tick();

        // Legal config with avl=0: no strip, done, vill=0
        applyStimulus(3'b000, 3'b000, 16'd0);
        tick();
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_vill", 32'(vill), 32'd0);
        checkOutput("t4_no_strip", 32'(strip_valid), 32'd0);
        checkOutput("t4_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("t4_vlmax", 32'(vlmax), 32'd16);
        tick();

        // SEW8 LMUL8 avl=300, abort with strip_ready on the second strip
        applyStimulus(3'b000, 3'b011, 16'd300);
        tick();
        checkOutput("t5_vlmax", 32'(vlmax), 32'd128);
        checkStrip("t5_s0", 128, 172, 1'b0);
        strip_ready = 1'b1;
        tick();
        checkStrip("t5_s1", 128, 44, 1'b0);
        abort = 1'b1;
        tick();
        abort       = 1'b0;
        strip_ready = 1'b0;
        checkOutput("t5_abort_valid", 32'(strip_valid), 32'd0);
        checkOutput("t5_abort_rem", 32'(avl_remaining), 32'd0);
        checkOutput("t5_abort_done", 32'(done), 32'd1);
        checkOutput("t5_abort_idle", 32'(cfg_ready), 32'd1);
        tick();
        checkOutput("t5_no_third", 32'(strip_valid), 32'd0);
        checkOutput("t5_done_end", 32'(done), 32'd0);

        // Asynchronous reset during ISSUE, then a normal configuration
        applyStimulus(3'b001, 3'b000, 16'd20);
        tick();
        checkStrip("t6_s0", 8, 12, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_valid", 32'(strip_valid), 32'd0);
        checkOutput("t6_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("t6_rst_vl", 32'(strip_vl), 32'd0);
        checkOutput("t6_rst_rem", 32'(avl_remaining), 32'd0);
        checkOutput("t6_rst_vlmax", 32'(vlmax), 32'd0);
        checkOutput("t6_rst_last", 32'(strip_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        applyStimulus(3'b010, 3'b000, 16'd5);
        tick();
        checkOutput("t6_vlmax", 32'(vlmax), 32'd4);
        checkStrip("t6_n0", 4, 1, 1'b0);
        strip_ready = 1'b1;
        tick();
        checkStrip("t6_n1", 1, 0, 1'b1);
        tick();
        strip_ready = 1'b0;
        checkOutput("t6_done", 32'(done), 32'd1);
        checkOutput("t6_valid_off", 32'(strip_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
